// File: rtl/var_assign_table.sv
// rtl/var_assign_table.sv - per-variable assignment/level table with backtrack sweep
// Optional opposite-polarity conflict detection: CONFLICT_DETECT_EN
module var_assign_table #(
    parameter int ADDR_WIDTH  = 3,
    parameter int NUM_VARS    = 8,
    parameter int LEVEL_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic [1:0]             cmd,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic                   din_val,
    input  logic [LEVEL_WIDTH-1:0] din_level,
    output logic [1:0]             dout_state,
    output logic [LEVEL_WIDTH-1:0] dout_level,
    output logic                   dout_valid,
    output logic                   busy,
    output logic                   bt_done,
    output logic [ADDR_WIDTH:0]    assigned_count
`ifdef CONFLICT_DETECT_EN
    ,
    output logic                   conflict
`endif
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} fsm_t;

    localparam logic [1:0] CMD_READ      = 2'b01;
    localparam logic [1:0] CMD_ASSIGN    = 2'b10;
    localparam logic [1:0] CMD_BACKTRACK = 2'b11;

    localparam logic [ADDR_WIDTH:0]   NUM_VARS_W = (ADDR_WIDTH+1)'(NUM_VARS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_VARS - 1);

    logic [1:0]             state_tbl [NUM_VARS];
    logic [LEVEL_WIDTH-1:0] level_tbl [NUM_VARS];

    fsm_t                   fsm;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [LEVEL_WIDTH-1:0] target;
    logic                   accept;
    logic                   addr_ok;
    logic [1:0]             cur_state;
    logic [LEVEL_WIDTH-1:0] cur_level;

    assign accept    = en && !busy;
    assign addr_ok   = {1'b0, address} < NUM_VARS_W;
    assign cur_state = addr_ok ? state_tbl[address] : 2'b00;
    assign cur_level = addr_ok ? level_tbl[address] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                state_tbl[i] <= 2'b00;
                level_tbl[i] <= '0;
            end
            fsm            <= IDLE;
            idx            <= '0;
            target         <= '0;
            dout_state     <= 2'b00;
            dout_level     <= '0;
            dout_valid     <= 1'b0;
            busy           <= 1'b0;
            bt_done        <= 1'b0;
            assigned_count <= '0;
`ifdef CONFLICT_DETECT_EN
            conflict       <= 1'b0;
`endif
        end else begin
            dout_valid <= 1'b0;
            bt_done    <= 1'b0;
`ifdef CONFLICT_DETECT_EN
            conflict   <= 1'b0;
`endif
            case (fsm)
                SWEEP: begin
                    if (state_tbl[idx][1] && (level_tbl[idx] > target)) begin
                        state_tbl[idx] <= 2'b00;
                        level_tbl[idx] <= '0;
                        assigned_count <= assigned_count - 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        fsm     <= DONE;
                        busy    <= 1'b0;
                        bt_done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept commands; DONE lasts one cycle
                    fsm <= IDLE;
                    if (accept) begin
                        case (cmd)
                            CMD_READ: begin
                                dout_valid <= 1'b1;
                                dout_state <= cur_state;
                                dout_level <= cur_level;
                            end
                            CMD_ASSIGN: begin
                                if (addr_ok) begin
`ifdef CONFLICT_DETECT_EN
                                    if (cur_state[1] && (cur_state[0] != din_val)) begin
                                        conflict <= 1'b1;
                                    end else begin
                                        state_tbl[address] <= {1'b1, din_val};
                                        level_tbl[address] <= din_level;
                                        if (!cur_state[1])
                                            assigned_count <= assigned_count + 1'b1;
                                    end
`else
                                    state_tbl[address] <= {1'b1, din_val};
                                    level_tbl[address] <= din_level;
                                    if (!cur_state[1])
                                        assigned_count <= assigned_count + 1'b1;
`endif
                                end
                            end
                            CMD_BACKTRACK: begin
                                target <= din_level;
                                idx    <= '0;
                                fsm    <= SWEEP;
                                busy   <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_var_assign_table.sv
// tb/tb_var_assign_table.sv - directed self-checking bench for var_assign_table
module tb_var_assign_table;

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_AS  = 2'b10;
    localparam logic [1:0] C_BT  = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [2:0] address = 3'd0;
    logic       din_val = 1'b0;
    logic [3:0] din_level = 4'd0;
    logic [1:0] dout_state;
    logic [3:0] dout_level;
    logic       dout_valid;
    logic       busy;
    logic       bt_done;
    logic [3:0] assigned_count;
`ifdef CONFLICT_DETECT_EN
    logic       conflict;
`endif

    int total = 0;
    int bad = 0;

    var_assign_table dut (
        .clock(clock),
        .reset(reset),
        .en(en),
        .cmd(cmd),
        .address(address),
        .din_val(din_val),
        .din_level(din_level),
        .dout_state(dout_state),
        .dout_level(dout_level),
        .dout_valid(dout_valid),
        .busy(busy),
        .bt_done(bt_done),
        .assigned_count(assigned_count)
`ifdef CONFLICT_DETECT_EN
        ,
        .conflict(conflict)
`endif
    );

    always #5 clock = ~clock;

    // Presents one command for one cycle; returns at the negedge after acceptance
    task automatic do_cmd(input logic [1:0] c, input logic [2:0] a,
                          input logic v, input logic [3:0] l);
        @(negedge clock);
        en = 1'b1; cmd = c; address = a; din_val = v; din_level = l;
        @(negedge clock);
        en = 1'b0; cmd = C_NOP;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        total++;
        if ({busy, bt_done, dout_valid} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {busy, bt_done, dout_valid});
        end
        total++;
        if ({dout_state, dout_level} !== 6'd0) begin
            bad++; $display("FAIL reset_dout: got %b/%0d want 00/0", dout_state, dout_level);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_cmd(C_RD, 3'(i), 1'b0, 4'd0);
            total++;
            if (dout_valid !== 1'b1 || dout_state !== 2'b00 || dout_level !== 4'd0) begin
                bad++;
                $display("FAIL reset_read[%0d]: got v=%b %b/%0d want v=1 00/0", i, dout_valid, dout_state, dout_level);
            end
        end
        @(negedge clock);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL read_pulse: got %b want 0", dout_valid);
        end
        total++;
        if (assigned_count !== 4'd0) begin
            bad++; $display("FAIL reset_count: got %0d want 0", assigned_count);
        end
    endtask

    task automatic test_assign();
        logic [1:0] es [4];
        logic [3:0] el [4];
        es = '{2'b11, 2'b10, 2'b11, 2'b10};
        el = '{4'd1, 4'd2, 4'd3, 4'd3};
        do_cmd(C_AS, 3'd0, 1'b1, 4'd1);
        do_cmd(C_AS, 3'd1, 1'b0, 4'd2);
        do_cmd(C_AS, 3'd2, 1'b1, 4'd3);
        do_cmd(C_AS, 3'd3, 1'b0, 4'd3);
        total++;
        if (assigned_count !== 4'd4) begin
            bad++; $display("FAIL assign_count: got %0d want 4", assigned_count);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(C_RD, 3'(i), 1'b0, 4'd0);
            total++;
            if (dout_valid !== 1'b1 || dout_state !== es[i] || dout_level !== el[i]) begin
                bad++;
                $display("FAIL assign_read[%0d]: got v=%b %b/%0d want v=1 %b/%0d", i, dout_valid, dout_state, dout_level, es[i], el[i]);
            end
        end
    endtask

    task automatic test_backtrack();
        int n;
        logic [1:0] es [4];
        logic [3:0] el [4];
        es = '{2'b11, 2'b10, 2'b00, 2'b00};
        el = '{4'd1, 4'd2, 4'd0, 4'd0};
        do_cmd(C_BT, 3'd0, 1'b0, 4'd2);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            total++;
            if (bt_done !== 1'b0) begin
                bad++; $display("FAIL bt_done_early: got %b want 0 at busy cycle %0d", bt_done, n);
            end
            n++;
            @(negedge clock);
        end
        total++;
        if (n !== 8) begin
            bad++; $display("FAIL busy_cycles: got %0d want 8", n);
        end
        total++;
        if (bt_done !== 1'b1) begin
            bad++; $display("FAIL bt_done: got %b want 1", bt_done);
        end
        @(negedge clock);
        total++;
        if (bt_done !== 1'b0) begin
            bad++; $display("FAIL bt_done_pulse: got %b want 0", bt_done);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(C_RD, 3'(i), 1'b0, 4'd0);
            total++;
            if (dout_valid !== 1'b1 || dout_state !== es[i] || dout_level !== el[i]) begin
                bad++;
                $display("FAIL bt_read[%0d]: got v=%b %b/%0d want v=1 %b/%0d", i, dout_valid, dout_state, dout_level, es[i], el[i]);
            end
        end
        total++;
        if (assigned_count !== 4'd2) begin
            bad++; $display("FAIL bt_count: got %0d want 2", assigned_count);
        end
    endtask

    task automatic test_drop();
        int n;
        do_cmd(C_BT, 3'd0, 1'b0, 4'hF);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL drop_busy: got %b want 1", busy);
        end
        en = 1'b1; cmd = C_AS; address = 3'd5; din_val = 1'b1; din_level = 4'd1;
        @(negedge clock);
        cmd = C_RD;
        @(negedge clock);
        en = 1'b0; cmd = C_NOP;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL drop_read: got valid %b want 0", dout_valid);
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        total++;
        if (bt_done !== 1'b1) begin
            bad++; $display("FAIL drop_bt_done: got %b want 1 after %0d cycles", bt_done, n);
        end
        // READ presented in the DONE cycle must be accepted
        en = 1'b1; cmd = C_RD; address = 3'd0;
        @(negedge clock);
        en = 1'b0; cmd = C_NOP;
        total++;
        if (dout_valid !== 1'b1 || dout_state !== 2'b11 || dout_level !== 4'd1) begin
            bad++; $display("FAIL done_read0: got v=%b %b/%0d want v=1 11/1", dout_valid, dout_state, dout_level);
        end
        do_cmd(C_RD, 3'd5, 1'b0, 4'd0);
        total++;
        if (dout_valid !== 1'b1 || dout_state !== 2'b00 || dout_level !== 4'd0) begin
            bad++; $display("FAIL drop_read5: got v=%b %b/%0d want v=1 00/0", dout_valid, dout_state, dout_level);
        end
        total++;
        if (assigned_count !== 4'd2) begin
            bad++; $display("FAIL drop_count: got %0d want 2", assigned_count);
        end
        @(negedge clock);
        en = 1'b0; cmd = C_AS; address = 3'd5; din_val = 1'b1; din_level = 4'd1;
        @(negedge clock);
        cmd = C_NOP;
        do_cmd(C_RD, 3'd5, 1'b0, 4'd0);
        total++;
        if (dout_state !== 2'b00 || assigned_count !== 4'd2) begin
            bad++; $display("FAIL en_low: got %b count %0d want 00 count 2", dout_state, assigned_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic seen;
        logic [2:0] addrs [4];
        addrs = '{3'd0, 3'd1, 3'd6, 3'd7};
        do_cmd(C_AS, 3'd6, 1'b1, 4'd5);
        do_cmd(C_AS, 3'd7, 1'b0, 4'd6);
        total++;
        if (assigned_count !== 4'd4) begin
            bad++; $display("FAIL pre_count: got %0d want 4", assigned_count);
        end
        do_cmd(C_BT, 3'd0, 1'b0, 4'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (busy !== 1'b0 || bt_done !== 1'b0 || assigned_count !== 4'd0) begin
            bad++; $display("FAIL mid_reset: got busy=%b done=%b count=%0d want 0 0 0", busy, bt_done, assigned_count);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bt_done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_reset_quiet: got activity %b want 0", seen);
        end
        for (int i = 0; i < 4; i++) begin
            do_cmd(C_RD, addrs[i], 1'b0, 4'd0);
            total++;
            if (dout_valid !== 1'b1 || dout_state !== 2'b00 || dout_level !== 4'd0) begin
                bad++; $display("FAIL mid_reset_read[%0d]: got v=%b %b/%0d want v=1 00/0", addrs[i], dout_valid, dout_state, dout_level);
            end
        end
    endtask

    task automatic test_conflict();
        do_cmd(C_AS, 3'd4, 1'b1, 4'd1);
`ifdef CONFLICT_DETECT_EN
        total++;
        if (conflict !== 1'b0) begin
            bad++; $display("FAIL conflict_first: got %b want 0", conflict);
        end
`endif
        do_cmd(C_AS, 3'd4, 1'b0, 4'd2);
`ifdef CONFLICT_DETECT_EN
        total++;
        if (conflict !== 1'b1) begin
            bad++; $display("FAIL conflict_raise: got %b want 1", conflict);
        end
        @(negedge clock);
        total++;
        if (conflict !== 1'b0) begin
            bad++; $display("FAIL conflict_pulse: got %b want 0", conflict);
        end
        do_cmd(C_RD, 3'd4, 1'b0, 4'd0);
        total++;
        if (dout_state !== 2'b11 || dout_level !== 4'd1) begin
            bad++; $display("FAIL conflict_read: got %b/%0d want 11/1", dout_state, dout_level);
        end
`else
        do_cmd(C_RD, 3'd4, 1'b0, 4'd0);
        total++;
        if (dout_state !== 2'b10 || dout_level !== 4'd2) begin
            bad++; $display("FAIL overwrite_read: got %b/%0d want 10/2", dout_state, dout_level);
        end
`endif
        total++;
        if (assigned_count !== 4'd1) begin
            bad++; $display("FAIL conflict_count: got %0d want 1", assigned_count);
        end
        do_cmd(C_AS, 3'd4, 1'b1, 4'd3);
`ifdef CONFLICT_DETECT_EN
        total++;
        if (conflict !== 1'b0) begin
            bad++; $display("FAIL same_pol_conflict: got %b want 0", conflict);
        end
`endif
        do_cmd(C_RD, 3'd4, 1'b0, 4'd0);
        total++;
        if (dout_state !== 2'b11 || dout_level !== 4'd3 || assigned_count !== 4'd1) begin
            bad++; $display("FAIL reassign_read: got %b/%0d count %0d want 11/3 count 1", dout_state, dout_level, assigned_count);
        end
    endtask

    initial begin
        test_reset();
        test_assign();
        test_backtrack();
        test_drop();
        test_reset_mid_sweep();
        test_conflict();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/var_assign_table.md
Name: var_assign_table

Overview:
- Parametrised successor to the BCP variable table.
- Holds, per SAT variable, an assignment state (unassigned / false / true) and the decision level at which it was assigned.
- Supports single-cycle assign, registered read, and a multi-cycle backtrack sweep that unassigns every variable above a target decision level.
- Sits between the BCP implication engine (assign/read) and the decision/backtrack controller (backtrack), and keeps a live count of assigned variables.

Parameters:
- ADDR_WIDTH, 3, variable index width.
- NUM_VARS, 8, number of table entries; must be <= 2**ADDR_WIDTH.
- LEVEL_WIDTH, 4, decision-level field width.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  1  command enable; a command is accepted only when en=1 and busy=0
- cmd  in  2  00 NOP, 01 READ, 10 ASSIGN, 11 BACKTRACK
- address  in  ADDR_WIDTH  variable index for READ/ASSIGN
- din_val  in  1  polarity for ASSIGN (1=true, 0=false)
- din_level  in  LEVEL_WIDTH  decision level for ASSIGN; target level for BACKTRACK
- dout_state  out  2  READ result {assigned, value}: 00 unassigned, 10 false, 11 true
- dout_level  out  LEVEL_WIDTH  READ result level
- dout_valid  out  1  one-cycle pulse, READ result valid
- busy  out  1  backtrack sweep in progress
- bt_done  out  1  one-cycle pulse at sweep completion
- assigned_count  out  ADDR_WIDTH+1  number of entries currently assigned
- conflict  out  1  present only with CONFLICT_DETECT_EN

Behaviour:
- Reset (sync, active-high):
  - all entries go to state 00, level 0; FSM goes to IDLE.
  - Outputs: dout_state=0, dout_level=0, dout_valid=0, busy=0, bt_done=0, assigned_count=0, conflict=0.
  - Reset overrides any command and aborts a sweep in progress.
- Command acceptance:
  - A command is accepted only when en=1 and busy=0.
  - A command presented while busy=1 or en=0 is dropped, not queued.
- READ:
  - dout_state and dout_level are registered and appear the cycle after acceptance, with dout_valid=1 for exactly one cycle.
  - dout_state/dout_level hold their last value until the next READ.
  - address >= NUM_VARS returns 00 / level 0 with dout_valid=1.
- ASSIGN:
  - The entry takes {1, din_val} and din_level at the next edge.
  - assigned_count increments only if the entry was previously unassigned.
  - Re-assigning an already assigned entry overwrites it with no count change.
  - address >= NUM_VARS is ignored.
  - A READ of the same address in the following cycle returns the new value.
- BACKTRACK FSM, states IDLE -> SWEEP -> DONE -> IDLE:
  - On acceptance, latch the target level and go to SWEEP with idx=0.
  - busy=1 from the cycle after acceptance through the last SWEEP cycle.
  - SWEEP handles one entry per cycle. If the entry is assigned and its level > target, it is cleared to 00 / level 0 and assigned_count is decremented. Entries at level <= target are untouched.
  - After idx=NUM_VARS-1, go to DONE: bt_done=1 for one cycle, busy=0.
  - A command may be accepted in the DONE cycle.
  - Total busy time is exactly NUM_VARS cycles.
  - A target level of all-ones clears nothing but still sweeps the full table.
- Counter:
  - assigned_count never wraps; max value is NUM_VARS.
  - Increment and decrement cannot coincide, because ASSIGN cannot be accepted during SWEEP.
- Reset mid-sweep: table cleared, busy=0 at the next cycle, no bt_done pulse.

Optional Feature:
- Macro: CONFLICT_DETECT_EN.
- Defined:
  - The conflict output exists.
  - An ASSIGN to an entry already assigned with the opposite polarity does not modify the entry.
  - It raises conflict=1 for one cycle, the cycle after acceptance.
  - Same-polarity re-assign overwrites the level with no conflict.
- Undefined:
  - No conflict port.
  - Opposite-polarity ASSIGN overwrites like any other ASSIGN.

Test Plan:
- Reset, then READ addr 0..7 -> each gives dout_valid=1 one cycle later with dout_state=00, dout_level=0; assigned_count=0.
- ASSIGN (0,true,L1), (1,false,L2), (2,true,L3), (3,false,L3); READ 0..3 -> 11/1, 10/2, 11/3, 10/3; assigned_count=4.
- BACKTRACK target 2 -> busy high for exactly 8 cycles, then bt_done one cycle; READ 2,3 -> 00/0; READ 0,1 unchanged; assigned_count=2.
- Present ASSIGN (5,true,L1) and READ during busy -> both dropped; READ 5 after bt_done -> 00; en=0 with ASSIGN -> no change.
- Assert reset in the 4th SWEEP cycle -> busy=0 next cycle, no bt_done, all entries 00, assigned_count=0.
- With CONFLICT_DETECT_EN: ASSIGN (4,true,L1), then ASSIGN (4,false,L2) -> conflict=1 one cycle, READ 4 -> 11/1; without the macro -> READ 4 gives 10/2 and count stays 1.
